q16_mult_arbiter: RTL and testbench

- Shares one Q16.16 signed multiplier among NUM_REQ requesters.
- Round-robin arbitration with per-port valid/ready handshake.
- 2-stage pipelined multiply; optional saturation on overflow.
- Single shared response channel carrying requester ID, with backpressure. Sits between the fixed-point compute clients and the shared multiplier resource.

---
 rtl/q16_mult_arbiter_if.sv | 26 ++
 rtl/q16_mult_arbiter.sv | 164 ++++++++++++++++
 tb/tb_q16_mult_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/q16_mult_arbiter_if.sv
// Bundle of the requester and response channels of the shared Q16.16 multiplier.
// Handshake: a beat transfers on a rising edge where valid and ready are both high; valid and payload hold until then.
interface q16_mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_p;
    logic                  resp_ovf;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_p, resp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_p, resp_ovf
    );
endinterface

// File: rtl/q16_mult_arbiter.sv
// Round-robin shared Q16.16 signed multiplier: arbiter, S1 operand register, S2 product
// register and an output register with optional saturation; the whole pipe freezes on backpressure.
module q16_mult_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int FRACT_BITS = 16,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    q16_mult_arbiter_if.slave     bus,
    output logic                  busy,
    output logic [15:0]           ovf_count
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HI_W  = 64 - FRACT_BITS;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               s1_valid_q, s1_valid_d;
    logic signed [31:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [PTR_W-1:0]   s1_id_q, s1_id_d;
    logic               s2_valid_q, s2_valid_d;
    logic [HI_W-1:0]    s2_hi_q, s2_hi_d;
    logic [PTR_W-1:0]   s2_id_q, s2_id_d;
    logic               resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [31:0]        resp_p_q, resp_p_d;
    logic               resp_ovf_q, resp_ovf_d;
    logic [15:0]        ovf_count_q, ovf_count_d;

    logic               stall;
    logic               grant_valid;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand;
    logic [31:0]        sel_a, sel_b;
    logic [NUM_REQ-1:0] ready_vec;
    logic               hs;
    logic signed [63:0] prod;
    logic               unused_frac;
    logic [HI_W-32:0]   upper;
    logic               ovf;
    logic [31:0]        p_out;

    assign stall = resp_valid_q & ~bus.resp_ready;

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin : arbitrate
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        sel_a       = '0;
        sel_b       = '0;
        ready_vec   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_valid && bus.req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_a        = bus.req_a[i*32 +: 32];
                sel_b        = bus.req_b[i*32 +: 32];
                ready_vec[i] = grant_valid & ~stall & ~rst;
            end
        end
    end

    assign hs = grant_valid & ~stall & ~rst;

    assign prod = $signed({{32{s1_a_q[31]}}, s1_a_q}) * $signed({{32{s1_b_q[31]}}, s1_b_q});
    assign unused_frac = ^prod[FRACT_BITS-1:0];

    // Overflow when the bits above the Q16.16 window are not a pure sign extension.
    assign upper = s2_hi_q[HI_W-1:31];
    assign ovf   = ~((&upper) | ~(|upper));

    always_comb begin : format_result
        p_out = s2_hi_q[31:0];
        if (SATURATE != 0 && ovf) begin
            p_out = s2_hi_q[HI_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    always_comb begin : next_state
        ptr_d        = ptr_q;
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_id_d      = s1_id_q;
        s2_valid_d   = s2_valid_q;
        s2_hi_d      = s2_hi_q;
        s2_id_d      = s2_id_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_p_d     = resp_p_q;
        resp_ovf_d   = resp_ovf_q;
        ovf_count_d  = ovf_count_q;
        if (hs) begin
            ptr_d = grant_idx;
        end
        if (!stall) begin
            s1_valid_d = hs;
            if (hs) begin
                s1_a_d  = sel_a;
                s1_b_d  = sel_b;
                s1_id_d = grant_idx;
            end
            s2_valid_d   = s1_valid_q;
            s2_hi_d      = prod[63:FRACT_BITS];
            s2_id_d      = s1_id_q;
            resp_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                resp_id_d  = ID_W'(s2_id_q);
                resp_p_d   = p_out;
                resp_ovf_d = ovf;
            end
        end
        if (resp_valid_q && bus.resp_ready && resp_ovf_q && ovf_count_q != 16'hFFFF) begin
            ovf_count_d = ovf_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= PTR_W'(NUM_REQ - 1);
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_id_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_hi_q      <= '0;
            s2_id_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_p_q     <= '0;
            resp_ovf_q   <= 1'b0;
            ovf_count_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_id_q      <= s1_id_d;
            s2_valid_q   <= s2_valid_d;
            s2_hi_q      <= s2_hi_d;
            s2_id_q      <= s2_id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_p_q     <= resp_p_d;
            resp_ovf_q   <= resp_ovf_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign bus.req_ready  = ready_vec;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_p     = resp_p_q;
    assign bus.resp_ovf   = resp_ovf_q;
    assign busy           = s1_valid_q | s2_valid_q | resp_valid_q;
    assign ovf_count      = ovf_count_q;
endmodule

// File: tb/tb_q16_mult_arbiter.sv
// Directed bench for q16_mult_arbiter: latency, arithmetic, saturation, round-robin,
// backpressure and asynchronous reset, with an in-order response scoreboard.
module tb_q16_mult_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int EW      = ID_W + 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] ovf_count;

    q16_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    q16_mult_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .FRACT_BITS(16), .SATURATE(1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    int            n_total = 0;
    int            n_bad   = 0;
    int            n_resp  = 0;
    int            acc_cnt[NUM_REQ];
    logic [EW-1:0] exp_tab[NUM_REQ];
    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on each delivered beat, push the requester's expected result on each accept.
    task automatic mon();
        logic [EW-1:0] e;
        if (!rst) begin
            if (bus.resp_valid && bus.resp_ready) begin
                n_resp++;
                check("resp_outstanding", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("resp_beat", {bus.resp_id, bus.resp_p, bus.resp_ovf}, 64'(e));
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    exp_q.push_back(exp_tab[i]);
                    acc_cnt[i]++;
                end
            end
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        mon();
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ep, input logic eo);
        bus.req_a[idx*32 +: 32] = a;
        bus.req_b[idx*32 +: 32] = b;
        exp_tab[idx] = {ID_W'(idx), ep, eo};
    endtask

    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ep, input logic eo, input string tag);
        set_req(idx, a, b, ep, eo);
        bus.req_valid  = 4'b0001 << idx;
        bus.resp_ready = 1'b1;
        to_neg();
        check({tag, "_ready"}, 64'(bus.req_ready), 64'(4'b0001 << idx));
        to_drive();
        bus.req_valid = '0;
        to_neg();
        check({tag, "_lat1"}, 64'(bus.resp_valid), 64'd0);
        to_drive();
        to_neg();
        check({tag, "_lat2"}, 64'(bus.resp_valid), 64'd0);
        to_drive();
        to_neg();
        check({tag, "_valid"}, 64'(bus.resp_valid), 64'd1);
        check({tag, "_id"}, 64'(bus.resp_id), 64'(idx));
        check({tag, "_p"}, 64'(bus.resp_p), 64'(ep));
        check({tag, "_ovf"}, 64'(bus.resp_ovf), 64'(eo));
        to_drive();
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            to_neg();
            to_drive();
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        to_neg();
        to_drive();
        rst = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ovf_count", 64'(ovf_count), 64'd0);
    endtask

    initial begin
        int base_resp, base1, base2;
        logic done;
        rst            = 1'b1;
        bus.req_valid  = '1;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            acc_cnt[i] = 0;
            exp_tab[i] = '0;
        end
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_id", 64'(bus.resp_id), 64'd0);
        check("rst_resp_p", 64'(bus.resp_p), 64'd0);
        check("rst_resp_ovf", 64'(bus.resp_ovf), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovf_count", 64'(ovf_count), 64'd0);
        to_neg();
        to_drive();
        bus.req_valid = '0;
        to_neg();
        to_drive();
        rst = 1'b0;

        // Arithmetic, latency and saturation
        do_op(0, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0, "t1");
        do_op(0, 32'hFFFF_0000, 32'h0002_0000, 32'hFFFE_0000, 1'b0, "t2a");
        do_op(2, 32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_C000, 1'b0, "t2b");
        check("t2_ovf_count", 64'(ovf_count), 64'd0);
        do_op(1, 32'h0100_0000, 32'h0100_0000, 32'h7FFF_FFFF, 1'b1, "t3a");
        check("t3a_ovf_count", 64'(ovf_count), 64'd1);
        do_op(3, 32'h8000_0000, 32'h0002_0000, 32'h8000_0000, 1'b1, "t3b");
        check("t3b_ovf_count", 64'(ovf_count), 64'd2);
        do_op(1, 32'h7FFF_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 1'b0, "t3c");
        check("t3c_ovf_count", 64'(ovf_count), 64'd2);

        // Round-robin with every requester valid
        do_reset();
        base_resp = n_resp;
        set_req(0, 32'h0001_0000, 32'h0002_0000, 32'h0002_0000, 1'b0);
        set_req(1, 32'h0002_0000, 32'h0002_0000, 32'h0004_0000, 1'b0);
        set_req(2, 32'h0003_0000, 32'h0002_0000, 32'h0006_0000, 1'b0);
        set_req(3, 32'h0004_0000, 32'h0002_0000, 32'h0008_0000, 1'b0);
        bus.req_valid  = '1;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            to_neg();
            check("t4_grant", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            to_drive();
        end
        bus.req_valid = '0;
        wait_drain("t4_drain");
        check("t4_resp_count", 64'(n_resp - base_resp), 64'd8);

        // Backpressure with requesters 1 and 2
        base_resp = n_resp;
        base1     = acc_cnt[1];
        base2     = acc_cnt[2];
        set_req(1, 32'h0003_0000, 32'h0002_0000, 32'h0006_0000, 1'b0);
        set_req(2, 32'hFFFF_0000, 32'h0005_0000, 32'hFFFB_0000, 1'b0);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b0110;
        to_neg();
        check("t5_grant0", 64'(bus.req_ready), 64'h2);
        to_drive();
        to_neg();
        check("t5_grant1", 64'(bus.req_ready), 64'h4);
        to_drive();
        to_neg();
        check("t5_grant2", 64'(bus.req_ready), 64'h2);
        to_drive();
        for (int k = 0; k < 5; k++) begin
            to_neg();
            check("t5_stall_ready", 64'(bus.req_ready), 64'd0);
            check("t5_stall_valid", 64'(bus.resp_valid), 64'd1);
            check("t5_stall_id", 64'(bus.resp_id), 64'd1);
            check("t5_stall_p", 64'(bus.resp_p), 64'h0006_0000);
            to_drive();
        end
        bus.resp_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            bus.req_valid[1] = (acc_cnt[1] - base1) < 3;
            bus.req_valid[2] = (acc_cnt[2] - base2) < 3;
            if (bus.req_valid == '0 && exp_q.size() == 0) begin
                done = 1'b1;
            end else begin
                to_neg();
                to_drive();
            end
        end
        check("t5_done", 64'(done), 64'd1);
        check("t5_acc1", 64'(acc_cnt[1] - base1), 64'd3);
        check("t5_acc2", 64'(acc_cnt[2] - base2), 64'd3);
        check("t5_resp_count", 64'(n_resp - base_resp), 64'd6);

        // Asynchronous reset with two operations in flight
        set_req(0, 32'h0001_0000, 32'h0007_0000, 32'h0007_0000, 1'b0);
        set_req(1, 32'h0002_0000, 32'h0002_0000, 32'h0004_0000, 1'b0);
        bus.req_valid = 4'b0011;
        to_neg();
        to_drive();
        to_neg();
        to_drive();
        bus.req_valid = '0;
        to_neg();
        to_drive();
        to_neg();
        check("t6_pre_valid", 64'(bus.resp_valid), 64'd1);
        check("t6_pre_busy", 64'(busy), 64'd1);
        #2;
        rst           = 1'b1;
        bus.req_valid = '1;
        #1;
        check("t6_async_valid", 64'(bus.resp_valid), 64'd0);
        check("t6_async_busy", 64'(busy), 64'd0);
        check("t6_async_p", 64'(bus.resp_p), 64'd0);
        check("t6_async_id", 64'(bus.resp_id), 64'd0);
        check("t6_async_ovf", 64'(bus.resp_ovf), 64'd0);
        check("t6_async_ready", 64'(bus.req_ready), 64'd0);
        check("t6_async_ovf_count", 64'(ovf_count), 64'd0);
        exp_q.delete();
        base_resp = n_resp;
        to_drive();
        to_neg();
        to_drive();
        rst = 1'b0;
        to_neg();
        check("t6_first_grant", 64'(bus.req_ready), 64'h1);
        to_drive();
        bus.req_valid = '0;
        for (int c = 0; c < 8; c++) begin
            to_neg();
            to_drive();
        end
        check("t6_resp_count", 64'(n_resp - base_resp), 64'd1);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
